dpwm_multi: RTL

- Parametrised multi-phase digital PWM with complementary outputs and dead-time insertion.
- Successor to the single-pair fixed-200 kHz DPWM: programmable period, N interleaved phases with programmable phase offsets, and validated configuration.
- Configuration passes through a one-deep shadow and applies only at a period boundary.
- Sits between the digital compensator (supplies ton) and the gate drivers of a multi-phase buck.

---
 rtl/dpwm_multi_if.sv | 26 ++
 rtl/dpwm_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dpwm_multi_if.sv
// Configuration handshake bundle for dpwm_multi. It carries one offered configuration
// (period, on-time, dead times, per-phase offsets) and the ready/reject feedback.
interface dpwm_multi_if #(
  parameter int CNT_W = 11,
  parameter int DT_W  = 5,
  parameter int N_PH  = 2
);
  logic                  i_cfg_valid;
  logic                  o_cfg_ready;
  logic [CNT_W-1:0]      i_ts;
  logic [CNT_W-1:0]      i_ton;
  logic [DT_W-1:0]       i_dt1;
  logic [DT_W-1:0]       i_dt2;
  logic [N_PH*CNT_W-1:0] i_ph_off;
  logic                  o_cfg_err;

  modport master (
    output i_cfg_valid, i_ts, i_ton, i_dt1, i_dt2, i_ph_off,
    input  o_cfg_ready, o_cfg_err
  );

  modport slave (
    input  i_cfg_valid, i_ts, i_ton, i_dt1, i_dt2, i_ph_off,
    output o_cfg_ready, o_cfg_err
  );
endinterface

// File: rtl/dpwm_multi.sv
// Multi-phase complementary DPWM with dead time, a one-deep config shadow applied at period
// boundaries, and enable gating. Optional soft-start ramp of on-time: define DPWM_SOFTSTART_EN.
module dpwm_multi #(
  parameter int CNT_W  = 11,
  parameter int DT_W   = 5,
  parameter int N_PH   = 2,
  parameter int TS_RST = 1000
) (
  input  logic            i_clk,
  input  logic            reset_n,
  input  logic            enable,
  dpwm_multi_if.slave     cfg,
  output logic            o_ts_last,
  output logic [N_PH-1:0] c1,
  output logic [N_PH-1:0] c2
);
  localparam int OFF_W = N_PH * CNT_W;
  localparam int SUM_W = CNT_W + 1;

  // Phase 0 always runs at the master count, so its offset slice is masked to zero on entry.
  localparam logic [OFF_W-1:0] PH0_MASK = {OFF_W{1'b1}} << CNT_W;

  typedef struct packed {
    logic [CNT_W-1:0] ts;
    logic [CNT_W-1:0] ton;
    logic [DT_W-1:0]  dt1;
    logic [DT_W-1:0]  dt2;
    logic [OFF_W-1:0] off;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    ts:  CNT_W'(TS_RST),
    ton: '0,
    dt1: '0,
    dt2: '0,
    off: '0
  };

  logic [CNT_W-1:0] count_q, count_d;
  cfg_t             act_q, act_d;
  cfg_t             shd_q, shd_d;
  logic             shd_full_q, shd_full_d;
  logic             run_q, run_d;
  logic             err_q, err_d;

  cfg_t             cfg_in;
  logic [SUM_W-1:0] span_in;
  logic             cfg_ok;
  logic             boundary;
  logic             offer;
  logic             accept;
  logic [CNT_W-1:0] ton_use;

  // ---------------------------------------------------------------------------
  // Incoming configuration and its validation
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_in.ts  = cfg.i_ts;
    cfg_in.ton = cfg.i_ton;
    cfg_in.dt1 = cfg.i_dt1;
    cfg_in.dt2 = cfg.i_dt2;
    cfg_in.off = cfg.i_ph_off & PH0_MASK;
  end

  always_comb begin
    span_in = SUM_W'(cfg_in.ton) + SUM_W'(cfg_in.dt1) + SUM_W'(cfg_in.dt2);
    cfg_ok  = (cfg_in.ts >= CNT_W'(2)) && (span_in <= SUM_W'(cfg_in.ts));
    for (int k = 1; k < N_PH; k++) begin
      if (cfg_in.off[k*CNT_W +: CNT_W] >= cfg_in.ts) begin
        cfg_ok = 1'b0;
      end
    end
  end

  assign boundary = (count_q == act_q.ts - 1'b1);
  // A busy shadow makes the offer invisible: no accept and no reject pulse.
  assign offer    = cfg.i_cfg_valid & ~shd_full_q;
  assign accept   = offer & cfg_ok;

  // ---------------------------------------------------------------------------
  // Next-state logic: counter, shadow/active config, run flag, reject pulse
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    count_d    = count_q + 1'b1;
    act_d      = act_q;
    shd_d      = shd_q;
    shd_full_d = shd_full_q;

    if (boundary) begin
      count_d = '0;
      if (accept) begin
        act_d = cfg_in;
      end else if (shd_full_q) begin
        act_d      = shd_q;
        shd_full_d = 1'b0;
      end
    end else if (accept) begin
      shd_d      = cfg_in;
      shd_full_d = 1'b1;
    end

    // Run only arms on a boundary, so the first enabled cycle is always count 0.
    run_d = enable & (boundary | run_q);
    err_d = offer & ~cfg_ok;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: clocked state uses <= only, so every register samples pre-edge values.
    if (!reset_n) begin
      count_q    <= '0;
      act_q      <= CFG_RST;
      shd_full_q <= 1'b0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      act_q      <= act_d;
      shd_full_q <= shd_full_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the shadow payload is only ever read while shd_full_q is set, so it needs no reset.
  always_ff @(posedge i_clk) begin
    shd_q <= shd_d;
  end

  // ---------------------------------------------------------------------------
  // Effective on-time
  // ---------------------------------------------------------------------------
`ifdef DPWM_SOFTSTART_EN
  logic [CNT_W-1:0] eff_ton_q, eff_ton_d;

  always_comb begin
    eff_ton_d = eff_ton_q;
    if (!run_d) begin
      eff_ton_d = '0;
    end else if (boundary && run_q) begin
      if (act_d.ton < eff_ton_q) begin
        eff_ton_d = act_d.ton;
      end else if (eff_ton_q < act_d.ton) begin
        eff_ton_d = eff_ton_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      eff_ton_q <= '0;
    end else begin
      eff_ton_q <= eff_ton_d;
    end
  end

  assign ton_use = eff_ton_q;
`else
  assign ton_use = act_q.ton;
`endif

  // ---------------------------------------------------------------------------
  // Per-phase waveform from the phase-local count
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] lc [N_PH];
  logic [SUM_W-1:0] edge_on;
  logic [SUM_W-1:0] edge_off;
  logic [SUM_W-1:0] edge_c2;
  logic             gate_on;

  assign edge_on  = SUM_W'(act_q.dt1);
  assign edge_off = edge_on + SUM_W'(ton_use);
  assign edge_c2  = edge_off + SUM_W'(act_q.dt2);
  assign gate_on  = reset_n & run_q & enable;

  always_comb begin
    for (int k = 0; k < N_PH; k++) begin
      lc[k] = SUM_W'(count_q) + SUM_W'(act_q.off[k*CNT_W +: CNT_W]);
      if (lc[k] >= SUM_W'(act_q.ts)) begin
        lc[k] = lc[k] - SUM_W'(act_q.ts);
      end
    end
  end

  always_comb begin
    c1 = '0;
    c2 = '0;
    for (int k = 0; k < N_PH; k++) begin
      c1[k] = gate_on && (lc[k] >= edge_on) && (lc[k] < edge_off);
      c2[k] = gate_on && (lc[k] >= edge_c2);
    end
  end

  assign o_ts_last       = boundary;
  assign cfg.o_cfg_ready = ~shd_full_q;
  assign cfg.o_cfg_err   = err_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_no_shoot_through: assert property (@(posedge i_clk) disable iff (!reset_n)
    (c1 & c2) == '0);

  a_count_in_period: assert property (@(posedge i_clk) disable iff (!reset_n)
    count_q < act_q.ts);

endmodule
